// File: rtl/pipe_de_exe.sv
// Decode/Execute pipeline register with the EX-stage ALU and jal link mux.
// Every d* field is captured each rising edge; a bubble clears the control bits.
module pipe_de_exe (
    input  logic        clock,
    input  logic        resetn,
    input  logic        dwreg,
    input  logic        dm2reg,
    input  logic        dwmem,
    input  logic        djal,
    input  logic        daluimm,
    input  logic        dshift,
    input  logic [3:0]  daluc,
    input  logic [31:0] da,
    input  logic [31:0] db,
    input  logic [31:0] dimm,
    input  logic [31:0] dpc4,
    input  logic [4:0]  drn,
    input  logic        dbubble,
    output logic        ewreg,
    output logic        em2reg,
    output logic        ewmem,
    output logic [4:0]  ern,
    output logic [31:0] ealu,
    output logic [31:0] eb,
    output logic        ezero
);

    logic        r_wreg;
    logic        r_m2reg;
    logic        r_wmem;
    logic        r_jal;
    logic        r_aluimm;
    logic        r_shift;
    logic [3:0]  r_aluc;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_pc4;
    logic [4:0]  r_rn;

    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_result;

    // Control fields are squashed by a bubble; data fields always load.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wreg   <= 1'b0;
            r_m2reg  <= 1'b0;
            r_wmem   <= 1'b0;
            r_jal    <= 1'b0;
            r_aluimm <= 1'b0;
            r_shift  <= 1'b0;
            r_aluc   <= 4'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_imm    <= 32'd0;
            r_pc4    <= 32'd0;
            r_rn     <= 5'd0;
        end else begin
            r_wreg   <= dwreg  & ~dbubble;
            r_m2reg  <= dm2reg & ~dbubble;
            r_wmem   <= dwmem  & ~dbubble;
            r_jal    <= djal   & ~dbubble;
            r_rn     <= dbubble ? 5'd0 : drn;
            r_aluimm <= daluimm;
            r_shift  <= dshift;
            r_aluc   <= daluc;
            r_a      <= da;
            r_b      <= db;
            r_imm    <= dimm;
            r_pc4    <= dpc4;
        end
    end

    assign w_op_a  = r_shift  ? r_imm : r_a;
    assign w_op_b  = r_aluimm ? r_imm : r_b;
    assign w_shamt = w_op_a[4:0];

    always_comb begin
        w_result = 32'd0;
        case (r_aluc[2:0])
            3'b000: w_result = w_op_a + w_op_b;
            3'b100: w_result = w_op_a - w_op_b;
            3'b001: w_result = w_op_a & w_op_b;
            3'b101: w_result = w_op_a | w_op_b;
            3'b010: w_result = w_op_a ^ w_op_b;
            3'b110: w_result = {w_op_b[15:0], 16'd0};
            3'b011: w_result = w_op_b << w_shamt;
            3'b111: begin
                if (r_aluc[3])
                    w_result = $unsigned($signed(w_op_b) >>> w_shamt);
                else
                    w_result = w_op_b >> w_shamt;
            end
            default: w_result = 32'd0;
        endcase
    end

    // ezero reflects the ALU, not the link address.
    assign ezero  = (w_result == 32'd0);
    assign ealu   = r_jal ? (r_pc4 + 32'd4) : w_result;
    assign ern    = r_jal ? 5'd31 : r_rn;
    assign ewreg  = r_wreg;
    assign em2reg = r_m2reg;
    assign ewmem  = r_wmem;
    assign eb     = r_b;

endmodule

// File: tb/tb_pipe_de_exe.sv
// Directed plus random checks of pipe_de_exe against a behavioural reference.
module tb_pipe_de_exe;

  typedef struct packed {
    logic        wreg, m2reg, wmem, jal, aluimm, shift, bubble;
    logic [3:0]  aluc;
    logic [31:0] a, b, imm, pc4;
    logic [4:0]  rn;
  } stim_t;

  typedef struct packed {
    logic        wreg, m2reg, wmem;
    logic [4:0]  rn;
    logic [31:0] alu, b;
    logic        zero;
  } exp_t;

  logic        clock, resetn;
  logic        dwreg, dm2reg, dwmem, djal, daluimm, dshift, dbubble;
  logic [3:0]  daluc;
  logic [31:0] da, db, dimm, dpc4;
  logic [4:0]  drn;
  logic        ewreg, em2reg, ewmem, ezero;
  logic [4:0]  ern;
  logic [31:0] ealu, eb;

  exp_t  exp_q[$];
  stim_t s;
  int    checks = 0;
  int    errors = 0;
  logic [3:0] ops [9] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010,
                          4'b0110, 4'b0011, 4'b0111, 4'b1111};

  pipe_de_exe dut (
    .clock(clock), .resetn(resetn),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .djal(djal),
    .daluimm(daluimm), .dshift(dshift), .daluc(daluc),
    .da(da), .db(db), .dimm(dimm), .dpc4(dpc4), .drn(drn),
    .dbubble(dbubble),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ern(ern),
    .ealu(ealu), .eb(eb), .ezero(ezero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t model(input stim_t t);
    exp_t        e;
    logic [31:0] opa, opb, r;
    logic [4:0]  sh;
    opa = t.shift  ? t.imm : t.a;
    opb = t.aluimm ? t.imm : t.b;
    sh  = opa[4:0];
    casez (t.aluc)
      4'b?000: r = opa + opb;
      4'b?100: r = opa + (~opb) + 32'd1;
      4'b?001: r = opa & opb;
      4'b?101: r = opa | opb;
      4'b?010: r = opa ^ opb;
      4'b?110: r = opb * 32'h10000;
      4'b0011: r = opb << sh;
      4'b0111: r = opb >> sh;
      4'b1111: begin
        r = opb >> sh;
        for (int k = 0; k < 32; k++)
          if (opb[31] && (k > 31 - int'(sh))) r[k] = 1'b1;
      end
      default: r = 32'd0;
    endcase
    e.zero  = (r == 32'd0);
    e.alu   = (t.jal && !t.bubble) ? t.pc4 + 32'd4 : r;
    e.rn    = t.bubble ? 5'd0 : (t.jal ? 5'd31 : t.rn);
    e.wreg  = t.wreg  && !t.bubble;
    e.m2reg = t.m2reg && !t.bubble;
    e.wmem  = t.wmem  && !t.bubble;
    e.b     = t.b;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic apply(input stim_t t);
    dwreg = t.wreg; dm2reg = t.m2reg; dwmem = t.wmem; djal = t.jal;
    daluimm = t.aluimm; dshift = t.shift; dbubble = t.bubble;
    daluc = t.aluc; da = t.a; db = t.b; dimm = t.imm; dpc4 = t.pc4; drn = t.rn;
    exp_q.push_back(model(t));
  endtask

  task automatic collect(input string tag);
    exp_t e;
    @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".ewreg"},  {31'd0, ewreg},  {31'd0, e.wreg});
      chk({tag, ".em2reg"}, {31'd0, em2reg}, {31'd0, e.m2reg});
      chk({tag, ".ewmem"},  {31'd0, ewmem},  {31'd0, e.wmem});
      chk({tag, ".ern"},    {27'd0, ern},    {27'd0, e.rn});
      chk({tag, ".eb"},     eb,              e.b);
      chk({tag, ".ezero"},  {31'd0, ezero},  {31'd0, e.zero});
      if (!e.wreg || e.rn != 0 || e.alu != 0 || !e.zero || e.wmem)
        chk({tag, ".ealu"}, ealu, e.alu);
      else
        chk({tag, ".ealu"}, ealu, e.alu);
    end
  endtask

  task automatic step(input stim_t t, input string tag);
    @(negedge clock);
    apply(t);
    collect(tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ewreg"},  {31'd0, ewreg},  32'd0);
    chk({tag, ".em2reg"}, {31'd0, em2reg}, 32'd0);
    chk({tag, ".ewmem"},  {31'd0, ewmem},  32'd0);
    chk({tag, ".ern"},    {27'd0, ern},    32'd0);
    chk({tag, ".eb"},     eb,              32'd0);
    chk({tag, ".ealu"},   ealu,            32'd0);
    chk({tag, ".ezero"},  {31'd0, ezero},  32'd1);
  endtask

  initial begin
    resetn = 1'b0;
    s = '0;
    dwreg = 0; dm2reg = 0; dwmem = 0; djal = 0; daluimm = 0; dshift = 0;
    dbubble = 0; daluc = 0; da = 0; db = 0; dimm = 0; dpc4 = 0; drn = 0;
    #1;
    chk_reset_vals("reset_init");
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;

    s = '0; s.a = 32'd5; s.b = 32'd7; s.wreg = 1; s.rn = 5'd3;
    step(s, "add");
    chk("add.ealu_const", ealu, 32'd12);

    s = '0; s.a = 32'h1234; s.b = 32'h1234; s.aluc = 4'b0100; s.wreg = 1; s.rn = 5'd4;
    step(s, "sub_zero");
    chk("sub_zero.ezero_const", {31'd0, ezero}, 32'd1);

    s = '0; s.shift = 1; s.imm = 32'd4; s.b = 32'h80000000; s.aluc = 4'b1111; s.rn = 5'd5;
    step(s, "sra");
    chk("sra.ealu_const", ealu, 32'hF8000000);

    s = '0; s.aluimm = 1; s.imm = 32'h0000ABCD; s.aluc = 4'b0110; s.wreg = 1; s.rn = 5'd6;
    step(s, "lui");
    chk("lui.ealu_const", ealu, 32'hABCD0000);

    s = '0; s.shift = 1; s.imm = 32'd0; s.b = 32'h8000_00F1; s.aluc = 4'b0011; s.rn = 5'd7;
    step(s, "sll_by0");
    s.aluc = 4'b0111; s.imm = 32'h0000_0FE4;
    step(s, "srl_low5");

    s = '0; s.jal = 1; s.wreg = 1; s.pc4 = 32'h100; s.rn = 5'd9;
    step(s, "jal");
    chk("jal.ealu_const", ealu, 32'h104);
    chk("jal.ern_const", {27'd0, ern}, 32'd31);
    s.bubble = 1;
    step(s, "jal_bubble");
    chk("jal_bubble.ern_const", {27'd0, ern}, 32'd0);

    s = '0; s.wmem = 1; s.b = 32'hDEAD; s.rn = 5'd2;
    step(s, "store");
    chk("store.eb_const", eb, 32'hDEAD);
    s.bubble = 1;
    step(s, "store_bubble");
    s.wreg = 1;
    step(s, "bubble2");

    s = '0; s.a = 32'hFFFF_FFFF; s.b = 32'd1; s.wreg = 1; s.rn = 5'd1;
    step(s, "add_wrap");

    for (int i = 0; i < 40; i++) begin
      s.wreg = 1'($urandom_range(0, 1)); s.m2reg = 1'($urandom_range(0, 1));
      s.wmem = 1'($urandom_range(0, 1)); s.jal = ($urandom_range(0, 7) == 0);
      s.aluimm = 1'($urandom_range(0, 1)); s.shift = 1'($urandom_range(0, 1));
      s.bubble = ($urandom_range(0, 3) == 0);
      s.aluc = ops[$urandom_range(0, 8)];
      s.a = $urandom; s.b = $urandom; s.imm = $urandom; s.pc4 = $urandom;
      s.rn = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) s.b = s.a;
      step(s, "rand");
    end

    s = '0; s.wreg = 1; s.wmem = 1; s.a = 32'd3; s.b = 32'd4; s.rn = 5'd8;
    step(s, "pre_reset");
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    s = '0; s.wreg = 1; s.a = 32'd10; s.b = 32'd20; s.rn = 5'd12;
    @(posedge clock);
    #1;
    chk_reset_vals("reset_hold");
    @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("release.ewreg", {31'd0, ewreg}, 32'd0);
    chk("release.ewmem", {31'd0, ewmem}, 32'd0);
    apply(s);
    collect("first_load");
    chk("first_load.ealu_const", ealu, 32'd30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_de_exe.md
PIPE_DE_EXE -- requirements
Module: pipe_de_exe

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clock, resetn.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 dwreg, dm2reg, dwmem, djal, daluimm, dshift  input  1 each  decode-stage controls: register write, load-to-reg, memory write, jal, ALU B = immediate, ALU A = shift amount.
REQ-005 daluc  input  4  decode-stage ALU op.
REQ-006 da, db, dimm, dpc4  input  32 each  forwarded operand A, forwarded operand B, immediate/shift amount, PC+4.
REQ-007 drn  input  5  decode-stage destination register.
REQ-008 dbubble  input  1  insert a bubble instead of the decoded instruction.
REQ-009 ewreg, em2reg, ewmem  output  1 each  registered controls for the EX stage, forwarded back to decode and on to MEM.
REQ-010 ern  output  5  EX destination register; 31 for jal.
REQ-011 ealu  output  32  EX result: ALU output or link address.
REQ-012 eb  output  32  registered db, the store data for MEM.
REQ-013 ezero  output  1  ALU result equals zero.

Function
REQ-014 The D/E register SHALL latch all d* inputs on every rising clock edge; there is no enable and the stage never holds.
REQ-015 When dbubble=1 at an edge, the register SHALL load ewreg=0, em2reg=0, ewmem=0, ejal=0, and ern source 0; data fields load normally and are don't-care.
REQ-016 The ALU SHALL use operand A = edshift ? eimm : ea and operand B = edaluimm ? eimm : eb. Both selects are registered copies.
REQ-017 ALU ops, with X = don't care. All arithmetic is 32-bit modulo 2^32 with no overflow trap:
- x000 = A+B
- x100 = A-B
- x001 = A&B
- x101 = A|B
- x010 = A^B
- x110 = {B[15:0],16'b0}
- 0011 = B<<A[4:0]
- 0111 = B>>A[4:0] (logical)
- 1111 = B>>>A[4:0] (arithmetic)
REQ-018 Shift amounts SHALL use only A[4:0]; a shift by 0 passes B unchanged.
REQ-019 ealu SHALL equal epc4+4 when ejal=1 and the ALU result otherwise; the path is combinational from the registered state.
REQ-020 ern SHALL be 5'd31 when ejal=1 and the registered drn otherwise.
REQ-021 ezero SHALL equal (ALU result == 0), evaluated before the jal mux.
REQ-022 Latency SHALL be exactly one cycle from d* sampling to valid e* outputs.
REQ-023 A bubble SHALL never write state downstream: ewreg and ewmem stay 0 for the whole bubbled cycle.
REQ-024 Back-to-back bubbles SHALL each produce one inert cycle.
REQ-025 When dbubble=1 coincides with djal=1, the bubble wins: ejal=0, ern=0, ewreg=0.

Reset
REQ-026 While resetn=0, all registered fields SHALL be 0 immediately, independent of clock.
REQ-027 Consequently during reset: ewreg=em2reg=ewmem=0, ern=0, eb=0, ealu=0, ezero=1.
REQ-028 Reset asserted mid-instruction SHALL discard that instruction; no write enable may pulse on reset release.
REQ-029 The first rising edge with resetn=1 SHALL load normally.

Verification
REQ-030 Add: da=5, db=7, daluc=0000, dwreg=1, drn=3 -> next cycle ealu=12, ern=3, ewreg=1, ezero=0.
REQ-031 Sub to zero: da=db=32'h1234, daluc=0100 -> ezero=1, ealu=0.
REQ-032 Sra and lui:
- dshift=1, dimm=4, db=32'h80000000, daluc=1111 -> ealu=32'hF8000000.
- daluimm=1, dimm=32'h0000ABCD, daluc=0110 -> ealu=32'hABCD0000.
REQ-033 jal with bubble:
- djal=1, dpc4=32'h100 -> ealu=32'h104, ern=31.
- Same inputs plus dbubble=1 -> ewreg=0, ern=0.
REQ-034 Store then bubble: dwmem=1, db=32'hDEAD -> ewmem=1, eb=32'hDEAD; next edge with dbubble=1 -> ewmem=0.
REQ-035 Async reset: drive resetn=0 between clock edges while ewreg=1 -> all outputs reach reset values before the next edge; release, then one valid load.
